// File: rtl/lcd_nibble_ctrl.sv
// lcd_nibble_ctrl: HD44780 4-bit interface controller. Runs the power-on nibble init and
// config bytes, then sends one requested byte at a time as two timed E strobes.
`timescale 1ns/1ps
`default_nettype none

module lcd_nibble_ctrl #(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_INIT3 = 2000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       lcd_4,
  output logic       lcd_5,
  output logic       lcd_6,
  output logic       lcd_7
);

  localparam logic [CNT_W-1:0] L_PWRUP = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] L_INIT1 = CNT_W'(T_INIT1 - 1);
  localparam logic [CNT_W-1:0] L_INIT2 = CNT_W'(T_INIT2 - 1);
  localparam logic [CNT_W-1:0] L_INIT3 = CNT_W'(T_INIT3 - 1);
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_NIB   = CNT_W'(T_NIB - 1);
  localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] L_CLR   = CNT_W'(T_CLR - 1);

  typedef enum logic [3:0] {
    PWRUP, INIT_NIB, INIT_WAIT, IDLE, HI_SETUP, HI_PULSE,
    HI_HOLD, NIB_GAP, LO_SETUP, LO_PULSE, LO_HOLD, POST_WAIT
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic             nib_phase_q;
  logic [7:0]       byte_q;
  logic             rs_q;
  logic             e_q;
  logic [3:0]       nib_q;
  logic             ready_q;
  logic             done_q;
  logic [7:0]       cfg_next;

  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    case (i)
      2'd0:    cfg_byte = 8'h28;
      2'd1:    cfg_byte = 8'h06;
      2'd2:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] init_wait(input logic [1:0] i);
    case (i)
      2'd0:    init_wait = L_INIT1;
      2'd1:    init_wait = L_INIT2;
      default: init_wait = L_INIT3;
    endcase
  endfunction

  // idx_q is shared: init-nibble index, then config-byte index (3 wraps to 0 = first config byte)
  assign cfg_next = cfg_byte(idx_q + 2'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= PWRUP;
      cnt_q       <= L_PWRUP;
      idx_q       <= 2'd0;
      nib_phase_q <= 1'b1;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      e_q         <= 1'b0;
      nib_q       <= 4'h0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else if (state_q != IDLE && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      case (state_q)
        PWRUP: begin
          state_q <= INIT_NIB;
          cnt_q   <= L_SETUP;
          nib_q   <= 4'h3;
          rs_q    <= 1'b0;
        end
        INIT_NIB, HI_SETUP: begin
          state_q <= HI_PULSE;
          cnt_q   <= L_PULSE;
          e_q     <= 1'b1;
        end
        HI_PULSE: begin
          state_q <= HI_HOLD;
          cnt_q   <= L_HOLD;
          e_q     <= 1'b0;
        end
        HI_HOLD: begin
          state_q <= nib_phase_q ? INIT_WAIT : NIB_GAP;
          cnt_q   <= nib_phase_q ? init_wait(idx_q) : L_NIB;
        end
        INIT_WAIT: begin
          idx_q <= idx_q + 2'd1;
          cnt_q <= L_SETUP;
          if (idx_q != 2'd3) begin
            state_q <= INIT_NIB;
            nib_q   <= (idx_q == 2'd2) ? 4'h2 : 4'h3;
          end else begin
            state_q     <= HI_SETUP;
            nib_phase_q <= 1'b0;
            byte_q      <= cfg_next;
            nib_q       <= cfg_next[7:4];
          end
        end
        NIB_GAP: begin
          state_q <= LO_SETUP;
          cnt_q   <= L_SETUP;
          nib_q   <= byte_q[3:0];
        end
        LO_SETUP: begin
          state_q <= LO_PULSE;
          cnt_q   <= L_PULSE;
          e_q     <= 1'b1;
        end
        LO_PULSE: begin
          state_q <= LO_HOLD;
          cnt_q   <= L_HOLD;
          e_q     <= 1'b0;
        end
        LO_HOLD: begin
          state_q <= POST_WAIT;
          // clear/home commands need the long execution delay
          cnt_q   <= (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03))
                     ? L_CLR : L_CMD;
        end
        POST_WAIT: begin
          if (!done_q && idx_q != 2'd3) begin
            state_q <= HI_SETUP;
            cnt_q   <= L_SETUP;
            idx_q   <= idx_q + 2'd1;
            byte_q  <= cfg_next;
            nib_q   <= cfg_next[7:4];
            rs_q    <= 1'b0;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && ready_q) begin
            state_q <= HI_SETUP;
            cnt_q   <= L_SETUP;
            byte_q  <= req_data;
            rs_q    <= req_rs;
            nib_q   <= req_data[7:4];
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= PWRUP;
          cnt_q   <= L_PWRUP;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign init_done = done_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = e_q;
  assign lcd_4     = nib_q[0];
  assign lcd_5     = nib_q[1];
  assign lcd_6     = nib_q[2];
  assign lcd_7     = nib_q[3];

endmodule

`default_nettype wire

// File: tb/tb_lcd_nibble_ctrl.sv
// tb_lcd_nibble_ctrl: directed checks of init sequence, byte timing, handshake and async reset.
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_nibble_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  wire        req_ready, init_done, lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7;
  wire  [3:0] nib = {lcd_7, lcd_6, lcd_5, lcd_4};

  int n_tests = 0;
  int n_fail  = 0;

  // Edge (counted from reset release) at which each init/config E pulse is first seen high
  int         exp_rise[12] = '{102, 149, 176, 193, 210, 220, 237, 247, 264, 274, 291, 301};
  logic [3:0] exp_nib[12]  = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

  lcd_nibble_ctrl #(
    .T_PWRUP(100), .T_INIT1(40), .T_INIT2(20), .T_INIT3(10),
    .T_SETUP(2), .T_PULSE(4), .T_HOLD(1), .T_NIB(3),
    .T_CMD(10), .T_CLR(30), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_data(req_data),
    .init_done(init_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call right after releasing reset on a falling edge; ends 1 ns after edge 336 (first IDLE).
  task automatic check_init(input string tag);
    int   np = 0;
    int   w  = 0;
    logic pe = 1'b0;
    for (int t = 1; t <= 336; t++) begin
      @(posedge clk); #1;
      if (lcd_e && !pe) begin
        if (np < 12) begin
          chk({tag, "_rise"}, t, exp_rise[np]);
          chk({tag, "_nib"}, nib, exp_nib[np]);
          chk({tag, "_rs"}, lcd_rs, 1'b0);
        end
        np++;
      end
      if (lcd_e) w++;
      if (!lcd_e && pe) begin
        chk({tag, "_width"}, w, 4);
        w = 0;
      end
      if (t == 335) begin
        chk({tag, "_done_early"}, init_done, 1'b0);
        chk({tag, "_rdy_early"}, req_ready, 1'b0);
      end
      if (t == 336) begin
        chk({tag, "_done"}, init_done, 1'b1);
        chk({tag, "_rdy"}, req_ready, 1'b1);
      end
      chk({tag, "_rw"}, lcd_rw, 1'b0);
      pe = lcd_e;
    end
    chk({tag, "_npulse"}, np, 12);
  endtask

  // Call 1 ns after an edge with req_ready high; ends 1 ns after the edge where IDLE is re-entered.
  // occ = edges from accept to IDLE; with hold, req_valid stays high and data churns while busy.
  task automatic send_and_check(input string tag, input logic rs, input logic [7:0] d,
                                input int occ, input bit hold, input logic [7:0] nxt);
    int   np = 0;
    int   w  = 0;
    logic pe = 1'b0;
    chk({tag, "_rdy_in"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    req_rs   = ~rs;
    req_data = ~d;
    chk({tag, "_rdy_drop"}, req_ready, 1'b0);
    for (int t = 1; t <= occ; t++) begin
      @(posedge clk); #1;
      if (hold) req_data = (t == occ) ? nxt : 8'(t * 37);
      if (lcd_e && !pe) begin
        if (np == 0) begin
          chk({tag, "_hi_rise"}, t, 2);
          chk({tag, "_hi_nib"}, nib, d[7:4]);
        end else if (np == 1) begin
          chk({tag, "_lo_rise"}, t, 12);
          chk({tag, "_lo_nib"}, nib, d[3:0]);
        end
        chk({tag, "_rs"}, lcd_rs, rs);
        np++;
      end
      if (lcd_e) w++;
      if (!lcd_e && pe) begin
        chk({tag, "_width"}, w, 4);
        w = 0;
      end
      if (t == occ - 1) chk({tag, "_rdy_busy"}, req_ready, 1'b0);
      if (t == occ) chk({tag, "_rdy_back"}, req_ready, 1'b1);
      pe = lcd_e;
    end
    chk({tag, "_npulse"}, np, 2);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_e", lcd_e, 1'b0);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_nib", nib, 4'h0);
    chk("rst_rdy", req_ready, 1'b0);
    chk("rst_done", init_done, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_init("init1");

    // Data and command bytes: occupancy 27 edges for normal, 47 for clear/home
    send_and_check("data41", 1'b1, 8'h41, 27, 1'b0, 8'h00);
    send_and_check("cmd01", 1'b0, 8'h01, 47, 1'b0, 8'h00);
    send_and_check("cmd80", 1'b0, 8'h80, 27, 1'b0, 8'h00);
    send_and_check("data02", 1'b1, 8'h02, 27, 1'b0, 8'h00);
    send_and_check("cmd03", 1'b0, 8'h03, 47, 1'b0, 8'h00);

    // req_valid held high across back-to-back bytes with data churning while busy
    send_and_check("hold48", 1'b1, 8'h48, 27, 1'b1, 8'h69);
    send_and_check("hold69", 1'b1, 8'h69, 27, 1'b0, 8'h00);

    // Asynchronous reset in the middle of the low-nibble E pulse
    req_valid = 1'b1;
    req_rs    = 1'b0;
    req_data  = 8'h3C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (13) begin
      @(posedge clk); #1;
    end
    chk("mid_e_high", lcd_e, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_e", lcd_e, 1'b0);
    chk("async_rdy", req_ready, 1'b0);
    chk("async_done", init_done, 1'b0);
    chk("async_nib", nib, 4'h0);

    // 0x55 held valid from release: must wait for init, then go out exactly once
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_init("init2");
    send_and_check("held55", 1'b1, 8'h55, 27, 1'b0, 8'h00);
    begin
      int extra = 0;
      for (int t = 0; t < 30; t++) begin
        @(posedge clk); #1;
        if (lcd_e) extra++;
      end
      chk("held55_once", extra, 0);
      chk("held55_idle_rdy", req_ready, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
